// File: rtl/magnitude_comparator_serial_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | magnitude_comparator_serial_if: start/operand/result bundle for the      |
// | serial magnitude comparator.                    Revision: 1.0            |
// +--------------------------------------------------------------------------+
interface magnitude_comparator_serial_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             busy;
  logic             done;
  logic             a_greater;
  logic             equal;
  logic             b_greater;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, a_greater, equal, b_greater
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, a_greater, equal, b_greater
  );
endinterface
`default_nettype wire

// File: rtl/magnitude_comparator_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | magnitude_comparator_serial: multi-cycle MSB-first slice comparator with |
// | early exit. Signed mode built only with MAG_CMP_SIGNED_EN. Rev: 1.0      |
// +--------------------------------------------------------------------------+
module magnitude_comparator_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  magnitude_comparator_serial_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             busy_q;
  logic             done_q;
  logic             agt_q;
  logic             eq_q;
  logic             bgt_q;

  logic [WIDTH-1:0] sign_flip;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic             slice_gt;
  logic             slice_lt;
  logic             last_slice;

`ifdef MAG_CMP_SIGNED_EN
  // Inverting the sign bit at latch time maps two's complement onto unsigned order;
  // only slice 0 sees it, and the mode is frozen with the operands.
  assign sign_flip = {bus.is_signed, {(WIDTH-1){1'b0}}};
`else
  logic unused_is_signed;
  assign unused_is_signed = bus.is_signed;
  assign sign_flip        = '0;
`endif

  // Operands shift left each cycle so the active slice is always the top SLICE bits.
  assign slice_a    = a_q[WIDTH-1 -: SLICE];
  assign slice_b    = b_q[WIDTH-1 -: SLICE];
  assign slice_gt   = (slice_a > slice_b);
  assign slice_lt   = (slice_a < slice_b);
  assign last_slice = (idx_q == IDX_W'(NSLICE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      agt_q   <= 1'b0;
      eq_q    <= 1'b0;
      bgt_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a ^ sign_flip;
            b_q     <= bus.b ^ sign_flip;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (slice_gt || slice_lt || last_slice) begin
            agt_q   <= slice_gt;
            bgt_q   <= slice_lt;
            eq_q    <= !(slice_gt || slice_lt);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            a_q   <= a_q << SLICE;
            b_q   <= b_q << SLICE;
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.a_greater = agt_q;
  assign bus.equal     = eq_q;
  assign bus.b_greater = bgt_q;
endmodule
`default_nettype wire

// File: tb/tb_magnitude_comparator_serial.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_magnitude_comparator_serial: scoreboard bench for the serial          |
// | magnitude comparator (WIDTH=16, SLICE=4).       Revision: 1.0            |
// +--------------------------------------------------------------------------+
module tb_magnitude_comparator_serial;
  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam logic [2:0] AG = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] BG = 3'b001;

  typedef struct {
    logic [2:0] flags;
    int         lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t sb[$];

  magnitude_comparator_serial_if #(.WIDTH(WIDTH)) bus ();

  magnitude_comparator_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] flags_now();
    return {bus.a_greater, bus.equal, bus.b_greater};
  endfunction

  // Drive a request before an edge and record what the comparator must return.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [2:0] ef, input int lat);
    exp_t e;
    bus.start     = 1'b1;
    bus.a         = a;
    bus.b         = b;
    bus.is_signed = s;
    e.flags = ef;
    e.lat   = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done after an accept; reports latency, whether flags stayed put, and timeout.
  task automatic wait_done(input logic [2:0] prev, output int lat,
                           output bit held, output bit tmo);
    lat  = 0;
    held = 1'b1;
    tmo  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) begin
        tmo = 1'b0;
        break;
      end
      if (flags_now() != prev) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", bus.done); end
    checks++; if (flags_now() !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", flags_now()); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat; bit held, tmo; exp_t e;
    launch(16'h8000, 16'h7FFF, 1'b0, AG, 1);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b want=1", bus.busy); end
    wait_done(3'b000, lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo) begin failures++; $display("FAIL basic_timeout got=no_done want=done"); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL basic_flags got=%b want=%b", flags_now(), e.flags); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done got=%b want=0", bus.busy); end
    @(posedge clk); #1;
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL basic_done_width got=%b want=0", bus.done); end
    @(negedge clk);
  endtask

  task automatic test_equal_ignore_start();
    int lat; bit tmo; exp_t e; logic [2:0] prev;
    prev = flags_now();
    launch(16'h1234, 16'h1234, 1'b0, EQ, 4);
    // Hammer start with different operands while busy; none of it may take effect.
    bus.start = 1'b1; bus.a = 16'h0000; bus.b = 16'hFFFF;
    lat = 0; tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) bus.start = 1'b0;
      if (bus.done) begin tmo = 1'b0; break; end
      checks++; if (flags_now() !== prev) begin failures++; $display("FAIL eq_hold got=%b want=%b", flags_now(), prev); end
    end
    e = sb.pop_front();
    checks++; if (tmo) begin failures++; $display("FAIL eq_timeout got=no_done want=done"); end
    checks++; if (lat != e.lat) begin failures++; $display("FAIL eq_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL eq_flags got=%b want=%b", flags_now(), e.flags); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL eq_no_restart got=%b want=0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit held, tmo; exp_t e;
    launch(16'h1235, 16'h1234, 1'b0, AG, 4);
    wait_done(EQ, lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL b2b1_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (!held) begin failures++; $display("FAIL b2b1_hold got=changed want=held"); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL b2b1_flags got=%b want=%b", flags_now(), e.flags); end
    launch(16'h0001, 16'h0100, 1'b0, BG, 2);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b2_accept got=%b want=1", bus.busy); end
    wait_done(AG, lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL b2b2_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (!held) begin failures++; $display("FAIL b2b2_hold got=changed want=held"); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL b2b2_flags got=%b want=%b", flags_now(), e.flags); end
    @(negedge clk);
  endtask

  task automatic test_signed();
    int lat; bit held, tmo; exp_t e;
`ifdef MAG_CMP_SIGNED_EN
    launch(16'hFFFF, 16'h0001, 1'b1, BG, 1);
`else
    launch(16'hFFFF, 16'h0001, 1'b1, AG, 1);
`endif
    wait_done(flags_now(), lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL signed1_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL signed1_flags got=%b want=%b", flags_now(), e.flags); end
    @(negedge clk);
    launch(16'hFFFF, 16'h0001, 1'b0, AG, 1);
    wait_done(flags_now(), lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL signed0_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL signed0_flags got=%b want=%b", flags_now(), e.flags); end
    @(negedge clk);
    // Sign bits equal: the flip cancels and ordering falls to the last slice.
    launch(16'h8000, 16'h8001, 1'b1, BG, 4);
    wait_done(flags_now(), lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL signed_last_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL signed_last_flags got=%b want=%b", flags_now(), e.flags); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int lat; bit held, tmo; exp_t e; bit saw_done;
    launch(16'h00F0, 16'h00F1, 1'b0, BG, 4);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b want=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", bus.done); end
    checks++; if (flags_now() !== 3'b000) begin failures++; $display("FAIL abort_flags got=%b want=000", flags_now()); end
    saw_done = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (bus.done) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL abort_no_done got=pulse want=none"); end
    @(negedge clk);
    launch(16'h00F0, 16'h00F1, 1'b0, BG, 4);
    wait_done(3'b000, lat, held, tmo);
    e = sb.pop_front();
    checks++; if (tmo || lat != e.lat) begin failures++; $display("FAIL abort_restart_latency got=%0d want=%0d", lat, e.lat); end
    checks++; if (flags_now() !== e.flags) begin failures++; $display("FAIL abort_restart_flags got=%b want=%b", flags_now(), e.flags); end
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_equal_ignore_start();
    test_back_to_back();
    test_signed();
    test_reset_abort();
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_drain got=%0d want=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
